// File: rtl/lgate_selftest.sv
// lgate_selftest: drives all four a/b vectors into a 7-output gate block, checks each result after SETTLE cycles, and reports pass, per-gate fail flags and mismatch count
module lgate_selftest #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_vec,
  output logic [4:0] err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] v;
  logic [3:0] cnt;
  logic [6:0] expected, mismatch;
  logic go;
  assign go = start && (state == IDLE || state == DONE);
  assign expected = {~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  assign mismatch = gate_out ^ expected;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? WAIT : state;
      WAIT:       state_nxt = cnt == 4'd0 ? CHECK : WAIT;
      CHECK:      state_nxt = v == 2'd3 ? DONE : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      cnt <= '0;
      a <= 1'b0;
      b <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_vec <= '0;
      err_count <= '0;
    end else if (go) begin
      v <= '0;
      cnt <= 4'(SETTLE - 1);
      a <= 1'b0;
      b <= 1'b0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      fail_vec <= '0;
      err_count <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (state == CHECK) begin
      fail_vec <= fail_vec | mismatch;
      err_count <= err_count + 5'($countones(mismatch));
      if (v == 2'd3) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (fail_vec | mismatch) == 7'd0;
      end else begin
        v <= v + 2'd1;
        {a, b} <= v + 2'd1;
        cnt <= 4'(SETTLE - 1);
      end
    end
  end
endmodule

// File: doc/lgate_selftest.md
# lgate_selftest

Self-test sequencer for the two-input, seven-output gate block. It sits on both sides of that block. Upstream, it drives operands `a`/`b` through all four input combinations. Downstream, it samples the seven gate outputs after a settle window, checks them against the expected truth table, and reports per-gate pass/fail and a mismatch count. It lets a lab board or bench qualify the gate stage with a single `start` pulse.

## Interface
- `SETTLE`, default 2: cycles between driving a vector and sampling outputs; legal range 1..15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test run; sampled only in IDLE or DONE.
- `a`  out  1  operand A to the gate block (registered).
- `b`  out  1  operand B to the gate block (registered).
- `gate_out`  in  7  gate block results: bit0 AND, bit1 OR, bit2 XOR, bit3 NAND, bit4 NOR, bit5 XNOR, bit6 NOT(a).
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until next start or rst.
- `pass`  out  1  valid when done=1; 1 if no mismatch occurred.
- `fail_vec`  out  7  sticky per-gate mismatch flags, same bit order as gate_out.
- `err_count`  out  5  total mismatching bits over the run (max 28).

## Operation
- FSM states:
  - IDLE: after reset. start=1 → WAIT.
  - WAIT: counts SETTLE cycles, then → CHECK.
  - CHECK: lasts one cycle.
    - Vector index < 3 → WAIT with the next vector.
    - Index = 3 → DONE.
  - DONE: start=1 → WAIT (new run).
- Vector index v is 2 bits and runs 0,1,2,3. Drive a=v[1], b=v[0], giving the order 00, 01, 10, 11.
- Run start, on the edge that accepts start:
  - v←0, a←0, b←0.
  - fail_vec←0, err_count←0.
  - busy←1, done←0, pass←0.
  - Settle counter←SETTLE-1.
- Expected vector for CHECK, computed from registered a/b:
  - {~a, ~(a^b), ~(a|b), ~(a&b), a^b, a|b, a&b}, bit6 down to bit0.
- mismatch = gate_out ^ expected.
- On each CHECK edge:
  - fail_vec ← fail_vec | mismatch.
  - err_count ← err_count + popcount(mismatch). The 5-bit width cannot overflow; no saturation logic is required.
- Advancing past the last vector (CHECK with v=3):
  - busy←0, done←1.
  - pass ← ((fail_vec | mismatch) == 0).
  - a and b hold 1/1.
- start in WAIT or CHECK is ignored. The run continues and its counters are unaffected.
- start in DONE clears results on the accepting edge, exactly as from IDLE.
- gate_out is sampled only on CHECK edges. Values at any other time are don't-care.

## Timing
- Reset values:
  - FSM: IDLE; v=0.
  - Outputs: a=0, b=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0.
- rst asserted mid-run aborts on the next edge, restoring all reset values. rst has priority over start on the same edge.
- Edge numbering: start accepted at edge 0, so busy=1 and a/b=00 from edge 0.
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT, then 1 in CHECK.
- Vector k is sampled at edge (k+1)·(SETTLE+1), for k=0..3.
- done rises and busy falls at edge 4·(SETTLE+1). With SETTLE=2 this is edge 12.
- a/b change only on the run-start edge and on CHECK edges for v<3. They are stable for ≥SETTLE cycles before every sample.
- busy and done are never both 1.
- fail_vec and err_count update only on CHECK edges. They are stable in DONE.

## Test plan
- Correct gate block connected, SETTLE=2, 1-cycle start pulse:
  - a/b sequence 00, 01, 10, 11, each held 3 cycles.
  - done at edge 12, pass=1, fail_vec=0, err_count=0.
- gate_out bit2 (XOR) forced 0, rest correct:
  - Mismatches at vectors 01 and 10.
  - fail_vec=7'b0000100, err_count=2, pass=0.
- gate_out forced 7'h00 throughout:
  - Expected-1 bits per vector: 00→4, 01→4, 10→3, 11→3.
  - err_count=14, fail_vec=7'h7F, pass=0.
- start re-pulsed at edge 5 of a run: ignored, done still at edge 12. Then start pulsed in DONE:
  - done drops and fail_vec/err_count clear on the accepting edge.
  - Second run completes 12 cycles later.
- rst asserted at edge 7 with start also high:
  - All outputs at reset values after edge 7; FSM in IDLE.
  - A later start runs a full 12-cycle sequence.
- SETTLE=1, correct gate block:
  - Each vector held 2 cycles, done at edge 8, pass=1.
